// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned MAX_LATENCY = 15;

  // Wait-counter width: enough to hold LATENCY-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    int unsigned w;
    w = $clog2(lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word store: synchronous write, asynchronous read, single shared address.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelling data-memory responder: one request in flight, valid/ready on both sides.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned OB = $clog2(WORD_BYTES);
  localparam int unsigned CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY == 0) ? 0 : LATENCY - 1);

  if (LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end
  if (DEPTH_WORDS < 4) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS too small");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_write;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;

  logic          accept;
  logic          enter_resp;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic          mem_we;
  logic [31:0]   arr_rdata;

  assign accept = req_valid && req_ready;

  // With zero latency the access happens on the accepting edge, so it must
  // use the live request rather than the (not yet loaded) latch.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state == IDLE && accept && LATENCY == 0) enter_resp = 1'b1;
    if (state == WAIT && cnt == '0)              enter_resp = 1'b1;
  end

  assign acc_err = (|acc_addr[OB-1:0]) || (|acc_addr[31:AW+OB]);
  assign mem_we  = enter_resp && acc_write && !acc_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_addr[AW+OB-1:OB]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Shared entry into RESP, overriding the per-state next state above.
      if (enter_resp) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        resp_rdata <= (acc_write || acc_err) ? '0 : arr_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance against a word-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int checks   = 0;
  int failures = 0;
  int sel      = 0;
  int lat_cfg [2] = '{2, 0};

  logic [31:0] mem_m [2][256];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  // Reference: a byte-addressed memory of 256 words; bad addresses never touch it.
  function automatic void model(input int s, input bit w, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] rd, output bit er);
    er = (a % 4 != 0) || (a >= 32'd1024);
    rd = 32'h0;
    if (!er) begin
      if (w) mem_m[s][a / 4] = d;
      else   rd = mem_m[s][a / 4];
    end
  endfunction

  // Present a request on the selected instance; returns cycles from acceptance to resp_valid.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, output int lat);
    int n;
    @(negedge clk);
    req_write[sel]  = w;
    req_addr[sel]   = a;
    req_wdata[sel]  = d;
    req_valid[sel]  = 1'b1;
    resp_ready[sel] = 1'b0;
    n = 0;
    while (!req_ready[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL accept_timeout dut=%0d addr=%h got no req_ready, required req_ready=1", sel, a);
    end
    @(posedge clk);
    #1 req_valid[sel] = 1'b0;
    lat = 1;
    while (!resp_valid[sel] && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume(input int hold, output logic [31:0] rd, output bit er);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    rd = resp_rdata[sel];
    er = resp_err[sel];
    resp_ready[sel] = 1'b1;
    @(posedge clk);
    #1 resp_ready[sel] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_write[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0;   resp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1 || resp_valid[s] !== 1'b0 || resp_rdata[s] !== 32'h0 ||
          resp_err[s] !== 1'b0 || busy[s] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut=%0d got rdy=%b vld=%b rdata=%h err=%b busy=%b, required 1 0 0 0 0",
                 s, req_ready[s], resp_valid[s], resp_rdata[s], resp_err[s], busy[s]);
      end
    end
  endtask

  task automatic test_fill;
    logic [31:0] d, rd, exp_rd;
    bit er, exp_er;
    int lat;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        model(s, 1'b1, 32'(i * 4), d, exp_rd, exp_er);
        issue(1'b1, 32'(i * 4), d, lat);
        consume(0, rd, er);
        checks++;
        if (rd !== exp_rd || er !== exp_er) begin
          failures++;
          $display("FAIL fill dut=%0d word=%0d got rdata=%h err=%b, required %h %b", s, i, rd, er, exp_rd, exp_er);
        end
      end
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd;
    bit er;
    int lat;
    sel = 0;
    issue(1'b1, 32'h10, 32'hDEADBEEF, lat);
    consume(0, rd, er);
    mem_m[0][4] = 32'hDEADBEEF;
    checks++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL store_l2 got lat=%0d err=%b rdata=%h, required 3 0 00000000", lat, er, rd);
    end
    issue(1'b0, 32'h10, 32'h0, lat);
    consume(0, rd, er);
    checks++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_l2 got lat=%0d err=%b rdata=%h, required 3 0 deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_latency0;
    logic [31:0] rd;
    bit er;
    int lat;
    sel = 1;
    issue(1'b1, 32'h0, 32'h12345678, lat);
    consume(0, rd, er);
    mem_m[1][0] = 32'h12345678;
    checks++;
    if (lat != 1 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL store_l0 got lat=%0d err=%b rdata=%h, required 1 0 00000000", lat, er, rd);
    end
    issue(1'b0, 32'h0, 32'h0, lat);
    consume(0, rd, er);
    checks++;
    if (lat != 1 || er !== 1'b0 || rd !== 32'h12345678) begin
      failures++;
      $display("FAIL load_l0 got lat=%0d err=%b rdata=%h, required 1 0 12345678", lat, er, rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    bit er;
    int lat;
    sel = 0;
    issue(1'b1, 32'h12, 32'hFFFFFFFF, lat);
    consume(0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL misaligned_store got err=%b rdata=%h, required 1 00000000", er, rd);
    end
    issue(1'b0, 32'h10, 32'h0, lat);
    consume(0, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_after_misaligned got err=%b rdata=%h, required 0 deadbeef", er, rd);
    end
    issue(1'b0, 32'h400, 32'h0, lat);
    consume(0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL out_of_range_load got err=%b rdata=%h, required 1 00000000", er, rd);
    end
    issue(1'b0, 32'h3FC, 32'h0, lat);
    consume(0, rd, er);
    checks++;
    if (er !== 1'b0) begin
      failures++;
      $display("FAIL last_word_load got err=%b, required 0", er);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, exp_rd, d2, rd2;
    bit er, exp_er, er2;
    int lat;
    sel = 0;
    d2 = $urandom;
    model(0, 1'b0, 32'h10, 32'h0, exp_rd, exp_er);
    issue(1'b0, 32'h10, 32'h0, lat);
    req_write[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = d2; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== exp_rd || req_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cycle=%0d got vld=%b rdata=%h rdy=%b, required 1 %h 0",
                 i, resp_valid[0], resp_rdata[0], req_ready[0], exp_rd);
      end
    end
    consume(0, rd, er);
    checks++;
    if (rd !== exp_rd || er !== exp_er || req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release got rdata=%h err=%b rdy=%b busy=%b, required %h %b 1 0",
               rd, er, req_ready[0], busy[0], exp_rd, exp_er);
    end
    model(0, 1'b1, 32'h30, d2, exp_rd, exp_er);
    issue(1'b1, 32'h30, d2, lat);
    consume(0, rd2, er2);
    model(0, 1'b0, 32'h30, 32'h0, exp_rd, exp_er);
    issue(1'b0, 32'h30, 32'h0, lat);
    consume(0, rd2, er2);
    checks++;
    if (rd2 !== exp_rd || er2 !== 1'b0) begin
      failures++;
      $display("FAIL second_request got rdata=%h err=%b, required %h 0", rd2, er2, exp_rd);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, exp_rd;
    bit er, exp_er;
    int n;
    sel = 0;
    @(negedge clk);
    req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hAAAA5555; req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_inflight got busy=%b vld=%b, required 1 0", busy[0], resp_valid[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 ||
        resp_err[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got rdy=%b vld=%b rdata=%h err=%b busy=%b, required 1 0 0 0 0",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0], busy[0]);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model(0, 1'b0, 32'h20, 32'h0, exp_rd, exp_er);
    issue(1'b0, 32'h20, 32'h0, n);
    consume(0, rd, er);
    checks++;
    if (rd !== exp_rd || er !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load got rdata=%h err=%b, required %h 0", rd, er, exp_rd);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d, rd, exp_rd;
    bit w, er, exp_er;
    int lat, kind;
    for (int i = 0; i < 40; i++) begin
      sel  = i % 2;
      w    = 1'($urandom_range(0, 1));
      d    = $urandom;
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 15) * 4);
      if (kind == 0) a = a | 32'($urandom_range(1, 3));
      if (kind == 1) a = 32'h400 + 32'($urandom_range(0, 4095) * 4);
      model(sel, w, a, d, exp_rd, exp_er);
      issue(w, a, d, lat);
      consume($urandom_range(0, 3), rd, er);
      checks++;
      if (rd !== exp_rd || er !== exp_er || lat != lat_cfg[sel] + 1) begin
        failures++;
        $display("FAIL random i=%0d dut=%0d w=%b addr=%h got rdata=%h err=%b lat=%0d, required %h %b %0d",
                 i, sel, w, a, rd, er, lat, exp_rd, exp_er, lat_cfg[sel] + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_store_load;
    test_latency0;
    test_errors;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
